// File: rtl/regbank.sv
// rtl/regbank.sv - byte/pair register bank with pair load/inc/dec and pair-zero flag
module regbank #(
  parameter int DATASIZE = 8,
  parameter int REGCOUNT = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wenb,
  input  logic [ADDRSIZE-1:0]     waddr,
  input  logic [DATASIZE-1:0]     wdata,
  input  logic                    penb,
  input  logic [ADDRSIZE-2:0]     paddr,
  input  logic [1:0]              pmode,
  input  logic [2*DATASIZE-1:0]   pdata,
  input  logic [ADDRSIZE-1:0]     raddr0,
  input  logic [ADDRSIZE-1:0]     raddr1,
  output logic [DATASIZE-1:0]     rdata0,
  output logic [DATASIZE-1:0]     rdata1,
  input  logic [ADDRSIZE-2:0]     rpaddr,
  output logic [2*DATASIZE-1:0]   rpdata,
  output logic                    pzero
);

  localparam int PW = 2 * DATASIZE;

  logic [DATASIZE-1:0] regs [REGCOUNT];
  logic [PW-1:0]       pcur;
  logic [PW-1:0]       pres;
  logic                pact;

  // Pair result is formed on the full 2*DATASIZE word so carry/borrow crosses bytes.
  always_comb begin
    pcur = {regs[{paddr, 1'b0}], regs[{paddr, 1'b1}]};
    pres = pcur;
    pact = 1'b0;
    if (penb) begin
      case (pmode)
        2'b00:   begin pres = pdata;          pact = 1'b1; end
        2'b01:   begin pres = pcur + 1'b1;    pact = 1'b1; end
        2'b10:   begin pres = pcur - 1'b1;    pact = 1'b1; end
        default: begin pres = pcur;           pact = 1'b0; end
      endcase
    end
  end

  // Byte write takes priority over the pair result for its own byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGCOUNT; i++) begin
        regs[i] <= '0;
      end
      pzero <= 1'b0;
    end else begin
      for (int i = 0; i < REGCOUNT; i++) begin
        if (wenb && (waddr == ADDRSIZE'(i))) begin
          regs[i] <= wdata;
        end else if (pact && (paddr == (ADDRSIZE-1)'(i >> 1))) begin
          regs[i] <= i[0] ? pres[DATASIZE-1:0] : pres[PW-1:DATASIZE];
        end
      end
      if (pact) begin
        pzero <= (pres == '0);
      end
    end
  end

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];
  assign rpdata = {regs[{rpaddr, 1'b0}], regs[{rpaddr, 1'b1}]};

endmodule

// File: tb/tb_regbank.sv
// tb/tb_regbank.sv - directed self-checking bench for regbank
module tb_regbank;

  logic        clk;
  logic        rst;
  logic        wenb;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic        penb;
  logic [1:0]  paddr;
  logic [1:0]  pmode;
  logic [15:0] pdata;
  logic [2:0]  raddr0;
  logic [2:0]  raddr1;
  logic [7:0]  rdata0;
  logic [7:0]  rdata1;
  logic [1:0]  rpaddr;
  logic [15:0] rpdata;
  logic        pzero;

  int n_tests = 0;
  int n_fail  = 0;

  regbank #(.DATASIZE(8), .REGCOUNT(8), .ADDRSIZE(3)) dut (
    .clk(clk), .rst(rst), .wenb(wenb), .waddr(waddr), .wdata(wdata),
    .penb(penb), .paddr(paddr), .pmode(pmode), .pdata(pdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .rpaddr(rpaddr), .rpdata(rpdata), .pzero(pzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then drop the enables so each op lasts exactly one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    wenb = 1'b0;
    penb = 1'b0;
  endtask

  task automatic bw(input int a, input logic [7:0] d);
    waddr = 3'(a);
    wdata = d;
    wenb  = 1'b1;
  endtask

  task automatic pop(input int p, input logic [1:0] m, input logic [15:0] d);
    paddr = 2'(p);
    pmode = m;
    pdata = d;
    penb  = 1'b1;
  endtask

  task automatic rd_reg(input int a, input logic [7:0] e, input string tag);
    raddr0 = 3'(a);
    #1;
    check(tag, {24'h0, rdata0}, {24'h0, e});
  endtask

  task automatic rd_pair(input int p, input logic [15:0] e, input string tag);
    rpaddr = 2'(p);
    #1;
    check(tag, {16'h0, rpdata}, {16'h0, e});
  endtask

  task automatic chk_z(input logic e, input string tag);
    check(tag, {31'h0, pzero}, {31'h0, e});
  endtask

  initial begin
    rst = 1'b1; wenb = 1'b0; waddr = '0; wdata = '0;
    penb = 1'b0; paddr = '0; pmode = 2'b11; pdata = '0;
    raddr0 = '0; raddr1 = '0; rpaddr = '0;
    #2;
    // Give the bank nonzero contents and pzero=1 before reset.
    for (int i = 0; i < 8; i++) begin
      bw(i, 8'(8'h11 * (i + 1)));
      step();
    end
    pop(3, 2'b00, 16'h0000);
    step();
    raddr0 = 3'd1; raddr1 = 3'd2; rpaddr = 2'd1;
    #1;
    check("pre_rst_reg1", {24'h0, rdata0}, 32'h22);
    chk_z(1'b1, "pre_rst_pzero");
    #2;
    rst = 1'b0;
    #1;
    check("rst_rdata0", {24'h0, rdata0}, 32'h0);
    check("rst_rdata1", {24'h0, rdata1}, 32'h0);
    check("rst_rpdata", {16'h0, rpdata}, 32'h0);
    chk_z(1'b0, "rst_pzero");
    #2;
    rst = 1'b1;
    step();
    for (int i = 0; i < 8; i++) rd_reg(i, 8'h00, $sformatf("rel_reg%0d", i));

    // Byte write / readback, read-before-write on same cycle
    bw(0, 8'hAA);
    step();
    bw(1, 8'h55);
    step();
    bw(7, 8'hA5);
    raddr1 = 3'd7;
    #1;
    check("no_bypass", {24'h0, rdata1}, 32'h0);
    step();
    rd_reg(0, 8'hAA, "wr_reg0");
    rd_reg(1, 8'h55, "wr_reg1");
    rd_reg(7, 8'hA5, "wr_reg7");
    raddr0 = 3'd7; raddr1 = 3'd7;
    #1;
    check("same_addr", {16'h0, rdata0, rdata1}, 32'hA5A5);
    rd_pair(0, 16'hAA55, "pair0");

    // Pair load + increment with byte carry
    pop(2, 2'b00, 16'h00FF);
    step();
    rd_pair(2, 16'h00FF, "ld_p2");
    pop(2, 2'b01, 16'h0000);
    step();
    rd_pair(2, 16'h0100, "inc_p2");
    rd_reg(4, 8'h01, "inc_reg4");
    rd_reg(5, 8'h00, "inc_reg5");
    chk_z(1'b0, "inc_pzero0");
    pop(2, 2'b00, 16'hFFFF);
    step();
    chk_z(1'b0, "ld_ffff_pzero");
    pop(2, 2'b01, 16'h0000);
    step();
    rd_pair(2, 16'h0000, "inc_wrap");
    chk_z(1'b1, "inc_wrap_pzero");

    // Decrement wrap and pzero hold
    pop(1, 2'b00, 16'h0001);
    step();
    pop(1, 2'b10, 16'h0000);
    step();
    rd_pair(1, 16'h0000, "dec_zero");
    chk_z(1'b1, "dec_zero_pzero");
    pop(1, 2'b10, 16'h0000);
    step();
    rd_pair(1, 16'hFFFF, "dec_wrap");
    chk_z(1'b0, "dec_wrap_pzero");
    pop(1, 2'b11, 16'h0000);
    step();
    rd_pair(1, 16'hFFFF, "hold_data");
    chk_z(1'b0, "hold_pzero0");
    pop(1, 2'b00, 16'h0000);
    step();
    chk_z(1'b1, "ld0_pzero");
    bw(3, 8'h05);
    step();
    rd_pair(1, 16'h0005, "bw_pair1");
    chk_z(1'b1, "bw_keeps_pzero");
    pop(1, 2'b11, 16'h1234);
    step();
    chk_z(1'b1, "hold_pzero1");
    rd_pair(1, 16'h0005, "hold_noload");

    // Collisions
    pop(3, 2'b00, 16'h12FF);
    step();
    pop(3, 2'b01, 16'h0000);
    bw(6, 8'h77);
    step();
    rd_reg(6, 8'h77, "col6_reg6");
    rd_reg(7, 8'h00, "col6_reg7");
    chk_z(1'b0, "col6_pzero");
    pop(3, 2'b00, 16'h12FF);
    step();
    pop(3, 2'b01, 16'h0000);
    bw(7, 8'h77);
    step();
    rd_pair(3, 16'h1377, "col7_pair3");
    pop(3, 2'b00, 16'hFFFF);
    step();
    pop(3, 2'b01, 16'h0000);
    bw(6, 8'h77);
    step();
    rd_pair(3, 16'h7700, "colz_pair3");
    chk_z(1'b1, "colz_pzero_from_r");
    pop(3, 2'b10, 16'h0000);
    bw(0, 8'h3C);
    step();
    rd_pair(3, 16'h76FF, "indep_pair3");
    rd_reg(0, 8'h3C, "indep_reg0");

    // Reset mid-operation
    rd_pair(2, 16'h0000, "pre_mid_p2");
    bw(0, 8'hC3);
    pop(2, 2'b00, 16'hBEEF);
    raddr0 = 3'd0; rpaddr = 2'd2;
    #3;
    rst = 1'b0;
    #1;
    check("mid_reg0", {24'h0, rdata0}, 32'h0);
    check("mid_rpdata", {16'h0, rpdata}, 32'h0);
    wenb = 1'b0;
    penb = 1'b0;
    @(posedge clk);
    #2;
    check("mid_hold_reg0", {24'h0, rdata0}, 32'h0);
    rst = 1'b1;
    step();
    rd_reg(0, 8'h00, "post_reg0");
    rd_pair(2, 16'h0000, "post_p2");
    rd_pair(3, 16'h0000, "post_p3");
    chk_z(1'b0, "post_pzero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
